// File: rtl/score_keeper_if.sv
// Game-event and display bus for the breakout score keeper.
// The game logic drives the event pulses; the score keeper returns the
// packed-BCD digits and status flags that feed the hex decoders.
interface score_keeper_if #(
   parameter int DIGITS = 4,
   parameter int PTS_W  = 3
);
   logic                  new_game;
   logic                  hit_valid;
   logic [PTS_W-1:0]      hit_points;
   logic                  ball_lost;
   logic [4*DIGITS-1:0]   score_bcd;
   logic [4*DIGITS-1:0]   high_bcd;
   logic [3:0]            lives;
   logic                  game_over;
   logic                  busy;

   // Game logic side: issues events, observes the scoreboard.
   modport master (
      output new_game, hit_valid, hit_points, ball_lost,
      input  score_bcd, high_bcd, lives, game_over, busy
   );

   // Score keeper side.
   modport slave (
      input  new_game, hit_valid, hit_points, ball_lost,
      output score_bcd, high_bcd, lives, game_over, busy
   );
endinterface

// File: rtl/score_keeper.sv
// Breakout score keeper: buffers brick points in a saturating pending
// counter and drains them into a packed-BCD score one unit per cycle.
// Tracks lives and keeps the session high score across new games.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   PLAY  | game running; hits accepted, ball losses decrement lives
//   FLUSH | last life lost; drain remaining points, then latch high score
//   OVER  | game finished; everything holds until new_game
module score_keeper #(
   parameter int DIGITS      = 4,
   parameter int START_LIVES = 3,
   parameter int PTS_W       = 3
) (
   input  logic            clock,
   input  logic            resetn,
   score_keeper_if.slave   bus
);

   localparam int SCORE_W = 4 * DIGITS;
   localparam int PEND_W  = 6;
   // Wide enough for a saturated pend plus the largest hit.
   localparam int SUM_W   = 8;

   localparam logic [SCORE_W-1:0] ALL_NINES   = {DIGITS{4'h9}};
   localparam logic [3:0]         LIVES_INIT  = 4'(START_LIVES);
   localparam logic [SUM_W-1:0]   PEND_MAX    = SUM_W'((1 << PEND_W) - 1);

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      FLUSH = 2'd1,
      OVER  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [SCORE_W-1:0]   score;
   logic [SCORE_W-1:0]   score_next;
   logic [SCORE_W-1:0]   high;
   logic [SCORE_W-1:0]   high_next;
   logic [3:0]           lives;
   logic [3:0]           lives_next;
   logic [PEND_W-1:0]    pend;
   logic [PEND_W-1:0]    pend_next;
   logic                 busy_q;
   logic                 over_q;

   logic                 draining;
   logic [SUM_W-1:0]     hit_add;
   logic [SUM_W-1:0]     pend_sum;
   logic [SCORE_W-1:0]   score_step;

   // One-unit BCD increment with ripple carry across all digits.
   function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
      logic [SCORE_W-1:0] r;
      logic               carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
               carry       = 1'b1;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Drain-path arithmetic shared by PLAY and FLUSH; score pins at all-nines.
   always_comb begin
      draining   = (pend != '0);
      hit_add    = bus.hit_valid ? SUM_W'(bus.hit_points) : '0;
      pend_sum   = SUM_W'(pend) + hit_add - SUM_W'(draining);
      score_step = (score == ALL_NINES) ? score : bcd_inc(score);
   end

   // Next-state and next-value logic; new_game overrides everything.
   always_comb begin
      state_next = state;
      score_next = score;
      high_next  = high;
      lives_next = lives;
      pend_next  = pend;

      if (bus.new_game) begin
         state_next = PLAY;
         score_next = '0;
         lives_next = LIVES_INIT;
         pend_next  = '0;
      end else begin
         unique case (state)
            PLAY: begin
               if (draining) begin
                  score_next = score_step;
               end
               // A hit arriving with the final ball loss still counts.
               pend_next = (pend_sum > PEND_MAX) ? PEND_W'(PEND_MAX)
                                                 : pend_sum[PEND_W-1:0];
               if (bus.ball_lost) begin
                  if (lives > 4'd1) begin
                     lives_next = lives - 4'd1;
                  end else begin
                     lives_next = 4'd0;
                     state_next = FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (draining) begin
                  score_next = score_step;
                  pend_next  = pend - PEND_W'(1);
               end else begin
                  // Packed BCD orders the same as its decimal value.
                  if (score > high) begin
                     high_next = score;
                  end
                  state_next = OVER;
               end
            end
            OVER: begin
            end
            default: begin
               state_next = PLAY;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= PLAY;
      end else begin
         state <= state_next;
      end
   end

   // Score, high score, lives, pending points and registered status flags.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         score  <= '0;
         high   <= '0;
         lives  <= LIVES_INIT;
         pend   <= '0;
         busy_q <= 1'b0;
         over_q <= 1'b0;
      end else begin
         score  <= score_next;
         high   <= high_next;
         lives  <= lives_next;
         pend   <= pend_next;
         busy_q <= (pend_next != '0);
         over_q <= (state_next == OVER);
      end
   end

   assign bus.score_bcd = score;
   assign bus.high_bcd  = high;
   assign bus.lives     = lives;
   assign bus.game_over = over_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed game scenarios plus random play, every
// cycle compared against an integer-arithmetic model of the game rules.
module tb_score_keeper;

   localparam int DIGITS      = 4;
   localparam int START_LIVES = 3;
   localparam int PTS_W       = 3;
   localparam int MAX_SCORE   = 9999;
   localparam int PEND_CAP    = 63;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   score_keeper_if #(.DIGITS(DIGITS), .PTS_W(PTS_W)) bus ();

   score_keeper #(
      .DIGITS      (DIGITS),
      .START_LIVES (START_LIVES),
      .PTS_W       (PTS_W)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: plain integers for score, high, lives, pending points.
   int m_score;
   int m_high;
   int m_lives;
   int m_pend;
   bit m_flushing;
   bit m_over;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic void model_reset();
      m_score    = 0;
      m_high     = 0;
      m_lives    = START_LIVES;
      m_pend     = 0;
      m_flushing = 1'b0;
      m_over     = 1'b0;
   endfunction

   function automatic void model_step(input bit ng, input bit hv, input int hp, input bit bl);
      int p;
      if (ng) begin
         m_score    = 0;
         m_pend     = 0;
         m_lives    = START_LIVES;
         m_flushing = 1'b0;
         m_over     = 1'b0;
      end else if (m_over) begin
      end else if (m_flushing) begin
         if (m_pend > 0) begin
            m_pend  = m_pend - 1;
            m_score = (m_score < MAX_SCORE) ? m_score + 1 : m_score;
         end else begin
            if (m_score > m_high) m_high = m_score;
            m_flushing = 1'b0;
            m_over     = 1'b1;
         end
      end else begin
         p = m_pend + (hv ? hp : 0) - ((m_pend > 0) ? 1 : 0);
         if (p > PEND_CAP) p = PEND_CAP;
         if (m_pend > 0) m_score = (m_score < MAX_SCORE) ? m_score + 1 : m_score;
         m_pend = p;
         if (bl) begin
            if (m_lives > 1) m_lives = m_lives - 1;
            else begin
               m_lives    = 0;
               m_flushing = 1'b1;
            end
         end
      end
   endfunction

   task automatic check_outputs();
      check_val("score", 32'(bus.score_bcd), to_bcd(m_score));
      check_val("high",  32'(bus.high_bcd),  to_bcd(m_high));
      check_val("lives", 32'(bus.lives),     32'(m_lives));
      check_val("over",  32'(bus.game_over), 32'(m_over));
      check_val("busy",  32'(bus.busy),      32'(m_pend != 0));
   endtask

   // Present inputs for one cycle, clock, update the model, compare.
   task automatic step(input bit ng, input bit hv, input int hp, input bit bl);
      bus.new_game   = ng;
      bus.hit_valid  = hv;
      bus.hit_points = hp[PTS_W-1:0];
      bus.ball_lost  = bl;
      @(posedge clock);
      model_step(ng, hv, hp, bl);
      #1;
      bus.new_game  = 1'b0;
      bus.hit_valid = 1'b0;
      bus.ball_lost = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      @(posedge clock);
      #1;
      resetn = 1'b0;
      #2;
      model_reset();
      check_outputs();
      #3;
      resetn = 1'b1;
   endtask

   // Lose every remaining life, then wait (bounded) for the game to end.
   task automatic finish_game();
      int budget;
      budget = 0;
      while (!m_flushing && !m_over && budget < 20) begin
         step(0, 0, 0, 1);
         budget++;
      end
      budget = 0;
      while (!m_over && budget < 200) begin
         step(0, 0, 0, 0);
         budget++;
      end
      check_val("game_end_reached", 32'(bus.game_over), 32'd1);
   endtask

   task automatic add_points(input int total);
      int left;
      left = total;
      while (left > 0) begin
         if (left >= 7) begin
            step(0, 1, 7, 0);
            left -= 7;
         end else begin
            step(0, 1, left, 0);
            left = 0;
         end
      end
   endtask

   initial begin
      int budget;
      int need;
      bus.new_game   = 1'b0;
      bus.hit_valid  = 1'b0;
      bus.hit_points = '0;
      bus.ball_lost  = 1'b0;
      model_reset();
      #12;
      resetn = 1'b1;
      check_outputs();

      // Idle after reset.
      idle(10);
      check_val("rst_score", 32'(bus.score_bcd), 32'h0000);
      check_val("rst_lives", 32'(bus.lives), 32'd3);
      check_val("rst_busy",  32'(bus.busy), 32'd0);

      // 7 then 5 more: carry from digit 0 into digit 1.
      step(0, 1, 7, 0);
      idle(7);
      check_val("score_7", 32'(bus.score_bcd), 32'h0007);
      step(0, 1, 5, 0);
      for (int i = 0; i < 5; i++) begin
         check_val("busy_during_drain", 32'(bus.busy), 32'd1);
         step(0, 0, 0, 0);
      end
      check_val("score_12", 32'(bus.score_bcd), 32'h0012);
      check_val("busy_after_5", 32'(bus.busy), 32'd0);

      // Back-to-back hits with overlapping drain.
      step(0, 1, 7, 0);
      step(0, 1, 7, 0);
      step(0, 1, 7, 0);
      for (int i = 0; i < 18; i++) begin
         check_val("busy_continuous", 32'(bus.busy), 32'd1);
         step(0, 0, 0, 0);
      end
      idle(2);
      check_val("score_33", 32'(bus.score_bcd), 32'h0033);

      // Climb to 9997, then overflow attempt.
      apply_reset();
      budget = 0;
      while ((m_score + m_pend) < 9997 && budget < 12000) begin
         need = 9997 - m_score - m_pend;
         if (m_pend <= PEND_CAP - 7) step(0, 1, (need > 7) ? 7 : need, 0);
         else step(0, 0, 0, 0);
         budget++;
      end
      budget = 0;
      while (m_pend > 0 && budget < 100) begin
         step(0, 0, 0, 0);
         budget++;
      end
      check_val("score_9997", 32'(bus.score_bcd), 32'h9997);
      step(0, 1, 5, 0);
      idle(5);
      check_val("score_sat", 32'(bus.score_bcd), 32'h9999);
      check_val("busy_sat",  32'(bus.busy), 32'd0);

      // Lives run out with points pending; flush then game over.
      apply_reset();
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 1, 6, 0);
      step(0, 0, 0, 1);
      check_val("lives_0", 32'(bus.lives), 32'd0);
      step(0, 1, 7, 1);
      idle(8);
      check_val("flush_score", 32'(bus.score_bcd), 32'h0006);
      check_val("flush_high",  32'(bus.high_bcd),  32'h0006);
      check_val("flush_over",  32'(bus.game_over), 32'd1);
      step(0, 1, 5, 0);
      idle(3);
      check_val("over_hold", 32'(bus.score_bcd), 32'h0006);

      // High score survives a lower-scoring game.
      step(1, 0, 0, 0);
      add_points(42);
      finish_game();
      check_val("high_42", 32'(bus.high_bcd), 32'h0042);
      step(1, 0, 0, 0);
      check_val("ng_over", 32'(bus.game_over), 32'd0);
      check_val("ng_lives", 32'(bus.lives), 32'd3);
      add_points(30);
      finish_game();
      check_val("score_30", 32'(bus.score_bcd), 32'h0030);
      check_val("high_kept", 32'(bus.high_bcd), 32'h0042);
      step(1, 0, 0, 0);
      step(0, 1, 7, 0);
      step(1, 1, 7, 0);
      check_val("ng_hit_score", 32'(bus.score_bcd), 32'h0000);
      check_val("ng_hit_busy",  32'(bus.busy), 32'd0);
      idle(3);

      // Asynchronous reset mid-drain clears the high score too.
      step(0, 1, 7, 0);
      idle(2);
      apply_reset();
      check_val("arst_high", 32'(bus.high_bcd), 32'h0000);
      idle(2);

      // Random play.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) < 2,
              $urandom_range(0, 99) < 40,
              int'($urandom_range(0, 7)),
              $urandom_range(0, 99) < 4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
